uart_rx: RTL and testbench

Serial receiver for the BeagleWire UART path, the receive-side counterpart of `uart_tx`. It oversamples the asynchronous `rx` pin using the same `clk_div` and frame-format register fields as the transmitter. It deframes start, data, optional parity and stop bits, and emits each received word as a one-cycle write pulse into an RX FIFO. The host reads that FIFO over GPMC.

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling serial deframer (start/data/parity/stop) emitting one valid pulse per frame.
// Latency: valid one cycle after the last stop sample; no backpressure, the consumer must keep up.
module uart_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [15:0]           clk_div,
  input  logic [4:0]            bits_per_word,
  input  logic                  parity_en,
  input  logic                  parity_evan_odd,
  input  logic                  two_stop_bit,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK} state_t;

  typedef struct packed {
    logic [15:0] div;
    logic [3:0]  bpw;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
  } cfg_t;

  state_t      state;
  cfg_t        cfg;
  logic        sync1, rxs;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [15:0] shreg;
  logic        perr, ferr;
  logic        tick;
  logic [15:0] div_eff;
  logic [3:0]  bpw_eff;

  assign tick    = (cnt == 16'd1);
  assign div_eff = (clk_div < 16'd4) ? 16'd4 : clk_div;
  assign bpw_eff = (bits_per_word > 5'd15) ? 4'd15 : bits_per_word[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      cfg        <= '0;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1      <= rx;
      rxs        <= sync1;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state inside {START, DATA, PARITY, STOP1, STOP2})
        cnt <= tick ? cfg.div : cnt - 16'd1;

      case (state)
        IDLE: begin
          if (!rxs) begin
            // Config is frozen for the whole frame; first sample lands mid start bit.
            state <= START;
            cfg   <= '{div: div_eff, bpw: bpw_eff, par_en: parity_en,
                       par_odd: parity_evan_odd, two_stop: two_stop_bit};
            cnt   <= div_eff >> 1;
            shreg <= '0;
            idx   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg[idx] <= rxs;
            idx        <= idx + 4'd1;
            if (idx == cfg.bpw)
              state <= cfg.par_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (tick) begin
            perr  <= rxs ^ (^shreg) ^ cfg.par_odd;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (tick) begin
            ferr <= ferr | ~rxs;
            if (cfg.two_stop) begin
              state <= STOP2;
            end else begin
              state      <= DONE;
              valid      <= 1'b1;
              data_out   <= DATA_WIDTH'(shreg);
              parity_err <= perr;
              frame_err  <= ferr | ~rxs;
            end
          end
        end
        STOP2: begin
          if (tick) begin
            ferr       <= ferr | ~rxs;
            state      <= DONE;
            valid      <= 1'b1;
            data_out   <= DATA_WIDTH'(shreg);
            parity_err <= perr;
            frame_err  <= ferr | ~rxs;
          end
        end
        DONE: begin
          // A low stop bit means the line may be held in break; wait for it to release.
          if (ferr) begin
            state <= BREAK;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, valid pulses logged at negedge with cycle stamps.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] clk_div;
  logic [4:0]  bits_per_word;
  logic        parity_en;
  logic        parity_evan_odd;
  logic        two_stop_bit;
  logic [15:0] data_out;
  logic        valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          vcount = 0;
  int          vcyc[32];
  logic [15:0] vdat[32];
  logic        vperr[32];
  logic        vferr[32];

  uart_rx #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clk_div(clk_div), .bits_per_word(bits_per_word),
    .parity_en(parity_en), .parity_evan_odd(parity_evan_odd), .two_stop_bit(two_stop_bit),
    .data_out(data_out), .valid(valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      if (vcount < 32) begin
        vcyc[vcount]  = cyc;
        vdat[vcount]  = data_out;
        vperr[vcount] = parity_err;
        vferr[vcount] = frame_err;
      end
      vcount = vcount + 1;
    end
  end

  // Drives n line bits LSB first, each held for d clocks; call 1 time unit after a rising edge.
  task automatic send_bits(input logic [31:0] bits, input int n, input int d);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (d) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [4:0] bpw, input logic pen,
                         input logic podd, input logic two);
    clk_div = div; bits_per_word = bpw; parity_en = pen; parity_evan_odd = podd; two_stop_bit = two;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    set_cfg(16'd16, 5'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_8n1();
    int c, b;
    set_cfg(16'd16, 5'd7, 1'b0, 1'b0, 1'b0);
    b = vcount; c = cyc;
    send_bits({1'b1, 8'hA5, 1'b0}, 10, 16);
    idle(10);
    checks++; if (vcount - b !== 1) begin errors++; $display("FAIL 8n1_count: got %0d expected 1", vcount - b); end
    checks++; if (vcyc[b] !== c + 155) begin errors++; $display("FAIL 8n1_time: got %0d expected %0d", vcyc[b], c + 155); end
    checks++; if (vdat[b] !== 16'h00A5) begin errors++; $display("FAIL 8n1_data: got %h expected 00a5", vdat[b]); end
    checks++; if (vperr[b] !== 1'b0) begin errors++; $display("FAIL 8n1_perr: got %b expected 0", vperr[b]); end
    checks++; if (vferr[b] !== 1'b0) begin errors++; $display("FAIL 8n1_ferr: got %b expected 0", vferr[b]); end
  endtask

  task automatic test_parity();
    int c, b;
    // 0x41 has two ones: even parity bit is 0, so a 1 is wrong in even mode and right in odd mode.
    for (int m = 0; m < 2; m++) begin
      set_cfg(16'd8, 5'd6, 1'b1, m[0], 1'b0);
      b = vcount; c = cyc;
      send_bits({1'b1, 1'b1, 7'h41, 1'b0}, 10, 8);
      idle(10);
      checks++; if (vcount - b !== 1) begin errors++; $display("FAIL par%0d_count: got %0d expected 1", m, vcount - b); end
      checks++; if (vcyc[b] !== c + 79) begin errors++; $display("FAIL par%0d_time: got %0d expected %0d", m, vcyc[b], c + 79); end
      checks++; if (vdat[b] !== 16'h0041) begin errors++; $display("FAIL par%0d_data: got %h expected 0041", m, vdat[b]); end
      checks++; if (vperr[b] !== (m == 0)) begin errors++; $display("FAIL par%0d_perr: got %b expected %b", m, vperr[b], m == 0); end
    end
  endtask

  task automatic test_break();
    int c, b;
    set_cfg(16'd8, 5'd7, 1'b0, 1'b0, 1'b1);
    b = vcount; c = cyc;
    send_bits({1'b0, 1'b1, 8'h5A, 1'b0}, 11, 8);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_low: got %b expected 1", busy); end
    checks++; if (vcount - b !== 1) begin errors++; $display("FAIL break_count: got %0d expected 1", vcount - b); end
    checks++; if (vcyc[b] !== c + 87) begin errors++; $display("FAIL break_time: got %0d expected %0d", vcyc[b], c + 87); end
    checks++; if (vferr[b] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", vferr[b]); end
    checks++; if (vdat[b] !== 16'h005A) begin errors++; $display("FAIL break_data: got %h expected 005a", vdat[b]); end
    idle(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_release: got %b expected 0", busy); end
    idle(200);
    checks++; if (vcount - b !== 1) begin errors++; $display("FAIL break_no_second: got %0d expected 1", vcount - b); end
  endtask

  task automatic test_glitch();
    int b;
    set_cfg(16'd16, 5'd7, 1'b0, 1'b0, 1'b0);
    b = vcount;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    idle(200);
    checks++; if (vcount - b !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", vcount - b); end
  endtask

  task automatic test_back_to_back();
    int c, b;
    set_cfg(16'd16, 5'd7, 1'b0, 1'b0, 1'b0);
    b = vcount;
    send_bits({4'b1010}, 4, 16);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h expected 0000", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid); end
    rst = 1'b0;
    idle(300);
    checks++; if (vcount - b !== 0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", vcount - b); end
    b = vcount; c = cyc;
    send_bits({1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}, 20, 16);
    idle(20);
    checks++; if (vcount - b !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vcount - b); end
    checks++; if (vcyc[b] !== c + 155) begin errors++; $display("FAIL b2b_time: got %0d expected %0d", vcyc[b], c + 155); end
    checks++; if (vcyc[b+1] - vcyc[b] !== 160) begin errors++; $display("FAIL b2b_gap: got %0d expected 160", vcyc[b+1] - vcyc[b]); end
    checks++; if (vdat[b] !== 16'h003C) begin errors++; $display("FAIL b2b_data0: got %h expected 003c", vdat[b]); end
    checks++; if (vdat[b+1] !== 16'h00C3) begin errors++; $display("FAIL b2b_data1: got %h expected 00c3", vdat[b+1]); end
  endtask

  task automatic test_min_div_wide();
    int c, b;
    // Run 0: clk_div=2 and bits_per_word=31 clamp to 4 and 15; run 1 uses those values directly.
    for (int m = 0; m < 2; m++) begin
      if (m == 0) set_cfg(16'd2, 5'd31, 1'b0, 1'b0, 1'b0);
      else        set_cfg(16'd4, 5'd15, 1'b0, 1'b0, 1'b0);
      b = vcount; c = cyc;
      send_bits({1'b1, 16'hBEEF, 1'b0}, 18, 4);
      idle(20);
      checks++; if (vcount - b !== 1) begin errors++; $display("FAIL wide%0d_count: got %0d expected 1", m, vcount - b); end
      checks++; if (vcyc[b] !== c + 73) begin errors++; $display("FAIL wide%0d_time: got %0d expected %0d", m, vcyc[b], c + 73); end
      checks++; if (vdat[b] !== 16'hBEEF) begin errors++; $display("FAIL wide%0d_data: got %h expected beef", m, vdat[b]); end
      checks++; if (vferr[b] !== 1'b0) begin errors++; $display("FAIL wide%0d_ferr: got %b expected 0", m, vferr[b]); end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_min_div_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
